mdu_ctrl: RTL

Multi-cycle multiply/divide unit with its sequencing controller for the E stage of the P6 pipeline. Sits beside the single-cycle ALU, accepts mult/multu/div/divu/mthi/mtlo commands, and owns the HI/LO registers and a busy counter that models the fixed multi-cycle latency. It drives the D-stage stall request so that a later multiply/divide-class instruction waits for the unit.

---
 rtl/mdu_ctrl.sv | 209 ++++++++++++++++++++
 1 files changed

// File: rtl/mdu_ctrl.sv
// mdu_ctrl: multi-cycle multiply/divide unit for the E stage, owns HI/LO and the busy sequencer.
// Latency: mult/multu keep busy for MULT_CYCLES cycles and div/divu for DIV_CYCLES; mthi/mtlo write at the issuing edge.
// Backpressure: start is never refused; md_stall holds a D-stage mul/div-class instruction while busy or while a long op issues.
//
// Ports:
//   clk, reset      - rising-edge clock, asynchronous active-high reset
//   start, MDUOp    - one-cycle command strobe and opcode (0 none, 1 mult, 2 multu, 3 div,
//                     4 divu, 5 mfhi, 6 mflo, 7 mthi, 8 mtlo)
//   A, B            - rs / rt operands
//   D_is_md         - D-stage instruction belongs to the mul/div class
//   busy, md_stall  - long operation in progress / stall request to the hazard unit
//   HI, LO, out     - architectural HI/LO and the mfhi/mflo read data
//   flush           - aborts a running operation; present only when MDU_FLUSH_EN is defined
module mdu_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
`ifdef MDU_FLUSH_EN
  input  logic        flush,
`endif
  input  logic        start,
  input  logic [3:0]  MDUOp,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        D_is_md,
  output logic        busy,
  output logic        md_stall,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic [31:0] out
);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MFHI  = 4'd5;
  localparam logic [3:0] OP_MFLO  = 4'd6;
  localparam logic [3:0] OP_MTHI  = 4'd7;
  localparam logic [3:0] OP_MTLO  = 4'd8;

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW         = $clog2(MAX_CYCLES + 1);

  localparam logic [CW-1:0] MULT_CNT = CW'(MULT_CYCLES);
  localparam logic [CW-1:0] DIV_CNT  = CW'(DIV_CYCLES);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t        state;
  state_t        next_state;
  logic [CW-1:0] cnt;
  logic [31:0]   p_hi;
  logic [31:0]   p_lo;

  logic          abort;
  logic          is_mul;
  logic          is_long;
  logic          cmd_ok;

`ifdef MDU_FLUSH_EN
  assign abort = flush;
`else
  assign abort = 1'b0;
`endif

  assign is_mul  = (MDUOp == OP_MULT) | (MDUOp == OP_MULTU);
  assign is_long = is_mul | (MDUOp == OP_DIV) | (MDUOp == OP_DIVU);
  // A flush in the same cycle discards the command, whatever the opcode.
  assign cmd_ok  = start & ~abort & (state == S_IDLE);

  // ---------------------------------------------------------------------------
  // Arithmetic. The result is computed from the operands at acceptance, so only
  // the pending pair has to be held while the counter models the latency.
  // ---------------------------------------------------------------------------
  logic [63:0] a_sx;
  logic [63:0] b_sx;
  logic [63:0] prod_s;
  logic [63:0] prod_u;

  assign a_sx   = {{32{A[31]}}, A};
  assign b_sx   = {{32{B[31]}}, B};
  // Low 64 bits of the product of the sign-extended operands is the signed product.
  assign prod_s = a_sx * b_sx;
  assign prod_u = {32'd0, A} * {32'd0, B};

  logic        div_signed;
  logic        a_neg;
  logic        b_neg;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic [31:0] b_div;
  logic [31:0] q_mag;
  logic [31:0] r_mag;
  logic [31:0] quo;
  logic [31:0] rem;

  assign div_signed = (MDUOp == OP_DIV);
  assign a_neg      = div_signed & A[31];
  assign b_neg      = div_signed & B[31];
  // Magnitudes as unsigned; |0x80000000| = 0x80000000 fits, which makes
  // 0x80000000 / -1 come out as 0x80000000 rem 0 without a special case.
  assign a_mag      = a_neg ? (32'd0 - A) : A;
  assign b_mag      = b_neg ? (32'd0 - B) : B;
  // Keep the divider away from a zero divisor; that result is never used.
  assign b_div      = (B == 32'd0) ? 32'd1 : b_mag;
  assign q_mag      = a_mag / b_div;
  assign r_mag      = a_mag % b_div;
  // Quotient truncates toward zero; remainder takes the dividend's sign.
  assign quo        = (a_neg ^ b_neg) ? (32'd0 - q_mag) : q_mag;
  assign rem        = a_neg ? (32'd0 - r_mag) : r_mag;

  logic [31:0] res_hi;
  logic [31:0] res_lo;

  always_comb begin
    res_hi = HI;
    res_lo = LO;
    case (MDUOp)
      OP_MULT:  {res_hi, res_lo} = prod_s;
      OP_MULTU: {res_hi, res_lo} = prod_u;
      OP_DIV, OP_DIVU: begin
        // Zero divisor: the pending pair is the current HI/LO, so completion
        // leaves them unchanged after the full busy time.
        if (B != 32'd0) begin
          res_hi = rem;
          res_lo = quo;
        end
      end
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Sequencer: state register / next state / outputs.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE: begin
        if (cmd_ok && is_long) begin
          next_state = S_RUN;
        end
      end
      S_RUN: begin
        if (abort || (cnt == CNT_ONE)) begin
          next_state = S_IDLE;
        end
      end
      default: next_state = S_IDLE;
    endcase
  end

  always_comb begin
    busy     = (state == S_RUN);
    md_stall = D_is_md & (busy | (start & is_long));
    case (MDUOp)
      OP_MFHI: out = HI;
      OP_MFLO: out = LO;
      default: out = 32'd0;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Counter, pending result and architectural HI/LO.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt  <= '0;
      p_hi <= '0;
      p_lo <= '0;
      HI   <= '0;
      LO   <= '0;
    end else if (state == S_RUN) begin
      if (abort) begin
        // Pending result is dropped; HI/LO keep their pre-operation values.
        cnt <= '0;
      end else begin
        cnt <= cnt - CNT_ONE;
        if (cnt == CNT_ONE) begin
          HI <= p_hi;
          LO <= p_lo;
        end
      end
    end else if (cmd_ok) begin
      if (is_long) begin
        cnt  <= is_mul ? MULT_CNT : DIV_CNT;
        p_hi <= res_hi;
        p_lo <= res_lo;
      end else if (MDUOp == OP_MTHI) begin
        HI <= A;
      end else if (MDUOp == OP_MTLO) begin
        LO <= A;
      end
    end
  end

endmodule
